pattern_lock_checker: RTL

// - Receive end of the periodic-pattern link: checks a serial bit stream from a

---
 rtl/pattern_lock_checker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pattern_lock_checker.sv
// ---------------------------------------------------------------------------
// pattern_lock_checker
//
// Receive-side checker for a fixed-period serial pattern. It hunts for the
// phase alignment of the incoming stream, declares lock after a run of
// matching bits, counts bit errors while locked and drops lock after a run
// of consecutive mismatches.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous, active-low reset
//   din_valid  din carries a bit this cycle
//   din        serial pattern bit
//   clear_err  synchronous clear of err_count / lock_lost
//   locked     1 while in LOCKED or SUSPECT
//   phase      phase whose expected bit is compared next
//   err_pulse  one-cycle pulse per counted bit error
//   err_count  saturating count of bit errors
//   lock_lost  sticky lock-loss flag
//
// Build option:
//   LOCK_LOSS_STICKY_EN  when defined, lock_lost sets on every lock-loss edge
//                        and holds until clear_err or reset. When undefined,
//                        lock_lost is tied to 0 and no flop is built for it.
// ---------------------------------------------------------------------------
module pattern_lock_checker #(
  parameter int                PERIOD   = 8,
  parameter logic [PERIOD-1:0] PATTERN  = 8'b0000_0100,
  parameter int                LOCK_CNT = 4,
  parameter int                LOSS_CNT = 3,
  parameter int                ERR_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       din_valid,
  input  logic                       din,
  input  logic                       clear_err,
  output logic                       locked,
  output logic [$clog2(PERIOD)-1:0]  phase,
  output logic                       err_pulse,
  output logic [ERR_W-1:0]           err_count,
  output logic                       lock_lost
);

  localparam int PH_W   = $clog2(PERIOD);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] LOCKED  = 2'd1;
  localparam logic [1:0] SUSPECT = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [PH_W-1:0]   phase_nxt;
  logic [PH_W-1:0]   phase_inc;
  logic [RUN_W-1:0]  match_run, match_run_nxt;
  logic [MISS_W-1:0] miss_run, miss_run_nxt;
  logic              match;
  logic              count_err;
  logic [ERR_W-1:0]  err_base;
  logic [ERR_W-1:0]  err_count_nxt;

  assign match = (din == PATTERN[phase]);

  assign phase_inc = (phase == PH_W'(PERIOD - 1)) ? '0 : phase + PH_W'(1);

  // Alignment state machine. A mismatch while hunting holds the phase so the
  // incoming stream slips by one bit relative to the local pattern, which
  // walks the alignment until a full run of matches is seen.
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    match_run_nxt = match_run;
    miss_run_nxt  = miss_run;
    count_err     = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (match) begin
            phase_nxt = phase_inc;
            if (match_run == RUN_W'(LOCK_CNT - 1)) begin
              state_nxt     = LOCKED;
              match_run_nxt = '0;
            end else begin
              match_run_nxt = match_run + RUN_W'(1);
            end
          end else begin
            match_run_nxt = '0;
          end
        end
        LOCKED: begin
          phase_nxt = phase_inc;
          if (!match) begin
            count_err = 1'b1;
            if (LOSS_CNT == 1) begin
              state_nxt     = HUNT;
              match_run_nxt = '0;
              miss_run_nxt  = '0;
            end else begin
              state_nxt    = SUSPECT;
              miss_run_nxt = MISS_W'(1);
            end
          end
        end
        SUSPECT: begin
          phase_nxt = phase_inc;
          if (match) begin
            state_nxt    = LOCKED;
            miss_run_nxt = '0;
          end else begin
            count_err = 1'b1;
            if (miss_run == MISS_W'(LOSS_CNT - 1)) begin
              state_nxt     = HUNT;
              match_run_nxt = '0;
              miss_run_nxt  = '0;
            end else begin
              miss_run_nxt = miss_run + MISS_W'(1);
            end
          end
        end
        default: begin
          state_nxt     = HUNT;
          match_run_nxt = '0;
          miss_run_nxt  = '0;
        end
      endcase
    end
  end

  // Clear is applied before the increment so that a clear coinciding with an
  // error leaves a count of one. The counter sticks at all-ones.
  always_comb begin
    err_base      = clear_err ? '0 : err_count;
    err_count_nxt = err_base;
    if (count_err && !(&err_base)) begin
      err_count_nxt = err_base + ERR_W'(1);
    end
  end

  // State and output registers. locked is registered from the next state so
  // it falls on the same edge that returns the machine to HUNT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      phase     <= '0;
      match_run <= '0;
      miss_run  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      match_run <= match_run_nxt;
      miss_run  <= miss_run_nxt;
      locked    <= (state_nxt != HUNT);
      err_pulse <= count_err;
      err_count <= err_count_nxt;
    end
  end

`ifdef LOCK_LOSS_STICKY_EN
  logic lose_lock;

  assign lose_lock = din_valid && (state != HUNT) && (state_nxt == HUNT);

  // Sticky loss flag; a loss on the same edge as a clear takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost <= 1'b0;
    end else if (lose_lock) begin
      lock_lost <= 1'b1;
    end else if (clear_err) begin
      lock_lost <= 1'b0;
    end
  end
`else
  assign lock_lost = 1'b0;
`endif

endmodule
